// File: rtl/spr_bank.sv
// Special-purpose register bank fed by one-hot write strobes, with in-place increment/clear,
// registered read port and counter taps. Optional read bypass: SPR_BANK_RD_BYPASS_EN.
module spr_bank #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned CORE_ID = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [14:0]       wtr_strobe,
   input  logic [DATA_W-1:0] bus_in,
   input  logic [3:0]        inc_sel,
   input  logic [3:0]        clr_sel,
   input  logic [3:0]        rd_sel,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] n_q,
   output logic [DATA_W-1:0] m_q,
   output logic [DATA_W-1:0] p_q,
   output logic [DATA_W-1:0] row_q,
   output logic [DATA_W-1:0] col_q,
   output logic [DATA_W-1:0] curr_q,
   output logic              row_last,
   output logic              col_last,
   output logic              multi_hot_err
);

   localparam logic [DATA_W-1:0] CoreIdRst = DATA_W'(CORE_ID);
   localparam logic [DATA_W-1:0] One       = DATA_W'(1);

   localparam int unsigned IdxN    = 1;
   localparam int unsigned IdxM    = 2;
   localparam int unsigned IdxP    = 3;
   localparam int unsigned IdxRow  = 5;
   localparam int unsigned IdxCol  = 6;
   localparam int unsigned IdxCurr = 7;
   localparam int unsigned IdxCore = 15;

   // Entry 0 is a permanent zero so an index of 0 reads back 0 without extra muxing.
   logic [DATA_W-1:0] regs_q [16];
   logic [DATA_W-1:0] regs_d [16];
   logic [DATA_W-1:0] rd_data_d;
   logic [DATA_W-1:0] row_nxt;
   logic [DATA_W-1:0] col_nxt;
   logic              multi_hot;

   // Later assignments win: write over clear over increment.
   always_comb begin
      regs_d[0] = '0;
      for (int unsigned i = 1; i < 16; i++) begin
         regs_d[i] = regs_q[i];
         if (inc_sel == 4'(i)) regs_d[i] = regs_q[i] + One;
         if (clr_sel == 4'(i)) regs_d[i] = '0;
         if (wtr_strobe[i-1])  regs_d[i] = bus_in;
      end
   end

   always_comb begin
`ifdef SPR_BANK_RD_BYPASS_EN
      rd_data_d = regs_d[rd_sel];
`else
      rd_data_d = regs_q[rd_sel];
`endif
   end

   assign multi_hot = |(wtr_strobe & (wtr_strobe - 15'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
         regs_q[IdxCore] <= CoreIdRst;
         rd_data         <= '0;
         multi_hot_err   <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         rd_data       <= rd_data_d;
         multi_hot_err <= multi_hot_err | multi_hot;
      end
   end

   assign n_q    = regs_q[IdxN];
   assign m_q    = regs_q[IdxM];
   assign p_q    = regs_q[IdxP];
   assign row_q  = regs_q[IdxRow];
   assign col_q  = regs_q[IdxCol];
   assign curr_q = regs_q[IdxCurr];

   assign row_nxt  = row_q + One;
   assign col_nxt  = col_q + One;
   assign row_last = (row_nxt == n_q);
   assign col_last = (col_nxt == p_q);

endmodule

// File: tb/tb_spr_bank.sv
// Scoreboard bench for spr_bank: stimulus pushes model predictions, a monitor pops and compares.
module tb_spr_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] wtr_strobe;
   logic [15:0] bus_in;
   logic [3:0]  inc_sel;
   logic [3:0]  clr_sel;
   logic [3:0]  rd_sel;
   logic [15:0] rd_data, n_q, m_q, p_q, row_q, col_q, curr_q;
   logic        row_last, col_last, multi_hot_err;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] rd;
      logic [15:0] n;
      logic [15:0] m;
      logic [15:0] p;
      logic [15:0] row;
      logic [15:0] col;
      logic [15:0] curr;
      logic        rl;
      logic        cl;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] mdl [16];
   logic        mdl_err;

   spr_bank #(.DATA_W(16), .CORE_ID(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .wtr_strobe    (wtr_strobe),
      .bus_in        (bus_in),
      .inc_sel       (inc_sel),
      .clr_sel       (clr_sel),
      .rd_sel        (rd_sel),
      .rd_data       (rd_data),
      .n_q           (n_q),
      .m_q           (m_q),
      .p_q           (p_q),
      .row_q         (row_q),
      .col_q         (col_q),
      .curr_q        (curr_q),
      .row_last      (row_last),
      .col_last      (col_last),
      .multi_hot_err (multi_hot_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs and predict the state seen after the next rising edge.
   task automatic apply(input logic r, input logic [14:0] s, input logic [15:0] d,
                        input logic [3:0] inc, input logic [3:0] clr, input logic [3:0] rs);
      logic [15:0] old_v [16];
      logic [15:0] new_v [16];
      exp_t        e;
      @(negedge clk);
      rst = r; wtr_strobe = s; bus_in = d; inc_sel = inc; clr_sel = clr; rd_sel = rs;
      if (r) begin
         for (int i = 0; i < 16; i++) mdl[i] = 16'd0;
         mdl[15] = 16'd3;
         mdl_err = 1'b0;
         e.rd    = 16'd0;
      end else begin
         old_v = mdl;
         new_v = mdl;
         if (inc != 0) new_v[inc] = old_v[inc] + 16'd1;
         if (clr != 0) new_v[clr] = 16'd0;
         for (int k = 0; k < 15; k++) if (s[k]) new_v[k+1] = d;
`ifdef SPR_BANK_RD_BYPASS_EN
         e.rd = (rs == 0) ? 16'd0 : new_v[rs];
`else
         e.rd = (rs == 0) ? 16'd0 : old_v[rs];
`endif
         if ($countones(s) > 1) mdl_err = 1'b1;
         mdl = new_v;
      end
      e.n    = mdl[1];
      e.m    = mdl[2];
      e.p    = mdl[3];
      e.row  = mdl[5];
      e.col  = mdl[6];
      e.curr = mdl[7];
      e.rl   = (16'(mdl[5] + 16'd1) == mdl[1]);
      e.cl   = (16'(mdl[6] + 16'd1) == mdl[3]);
      e.err  = mdl_err;
      exp_q.push_back(e);
   endtask

   // Monitor: every rising edge presents new outputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_data", rd_data, e.rd);
            chk("n_q", n_q, e.n);
            chk("m_q", m_q, e.m);
            chk("p_q", p_q, e.p);
            chk("row_q", row_q, e.row);
            chk("col_q", col_q, e.col);
            chk("curr_q", curr_q, e.curr);
            chk("row_last", 16'(row_last), 16'(e.rl));
            chk("col_last", 16'(col_last), 16'(e.cl));
            chk("multi_hot_err", 16'(multi_hot_err), 16'(e.err));
         end
      end
   end

   initial begin
      logic [14:0] s;
      logic [15:0] d;
      int          r;
      rst = 1'b1; wtr_strobe = '0; bus_in = '0; inc_sel = '0; clr_sel = '0; rd_sel = '0;
      for (int i = 0; i < 16; i++) mdl[i] = 16'd0;
      mdl_err = 1'b0;

      // Directed scenarios
      apply(1'b1, 15'h0000, 16'h0000, 4'd0, 4'd0, 4'd15);
      apply(1'b1, 15'h0000, 16'h0000, 4'd0, 4'd0, 4'd15);
      apply(1'b0, 15'h0000, 16'h0000, 4'd0, 4'd0, 4'd15);
      apply(1'b0, 15'h0001, 16'h0004, 4'd0, 4'd0, 4'd0);
      apply(1'b0, 15'h0010, 16'h0002, 4'd0, 4'd0, 4'd1);
      apply(1'b0, 15'h0000, 16'h0000, 4'd5, 4'd0, 4'd5);
      apply(1'b0, 15'h0010, 16'hFFFF, 4'd0, 4'd0, 4'd0);
      apply(1'b0, 15'h0000, 16'h0000, 4'd5, 4'd0, 4'd5);
      apply(1'b0, 15'h0020, 16'h0007, 4'd6, 4'd6, 4'd6);
      apply(1'b0, 15'h0080, 16'h00AA, 4'd0, 4'd0, 4'd0);
      apply(1'b0, 15'h0080, 16'h0055, 4'd0, 4'd0, 4'd8);
      apply(1'b0, 15'h0000, 16'h0000, 4'd0, 4'd0, 4'd8);
      apply(1'b0, 15'h4000, 16'h1234, 4'd0, 4'd0, 4'd15);
      apply(1'b0, 15'h0003, 16'h0009, 4'd0, 4'd0, 4'd15);
      apply(1'b0, 15'h0000, 16'h0000, 4'd0, 4'd0, 4'd2);
      apply(1'b1, 15'h0000, 16'h0000, 4'd0, 4'd0, 4'd0);
      apply(1'b0, 15'h0000, 16'h0000, 4'd0, 4'd0, 4'd15);

      // Randomized traffic, biased toward small values so the last-flags toggle.
      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3)      s = 15'd0;
         else if (r < 9) s = 15'd1 << $urandom_range(0, 14);
         else            s = 15'($urandom);
         r = int'($urandom_range(0, 3));
         if (r == 0)      d = 16'hFFFF;
         else if (r < 3)  d = 16'($urandom_range(0, 6));
         else             d = 16'($urandom);
         apply(($urandom_range(0, 99) < 2), s, d,
               4'($urandom_range(0, 15)),
               ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
               4'($urandom_range(0, 15)));
      end

      apply(1'b0, 15'h0000, 16'h0000, 4'd0, 4'd0, 4'd0);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
